// File: rtl/ht_res_fifo_if.sv
// Result payload type and the valid/ready stream interface that carries it
// between the per-direction result mux, the result FIFO and the consumer.
package ht_res_pkg;

    typedef struct packed {
        logic [15:0] key;
        logic [11:0] slot;
        logic [1:0]  dir;
        logic        hit;
        logic        err;
    } ht_result_t;

endpackage

interface ht_res_if;
    import ht_res_pkg::*;

    ht_result_t result;
    logic       valid;
    logic       ready;

    modport master (output result, output valid, input ready);
    modport slave  (input result, input valid, output ready);
endinterface

// File: rtl/ht_res_fifo.sv
// First-word-fall-through result FIFO with registered occupancy, status flags
// and free-running in/out transfer counters.
module ht_res_fifo
    import ht_res_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    ht_res_if.slave                  ht_res_in,
    ht_res_if.master                 ht_res_out,
    output logic [$clog2(DEPTH):0]   used_words_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic [31:0]              in_cnt_o,
    output logic [31:0]              out_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    ht_result_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   used_q;
    logic [CW-1:0]   used_nxt;
    logic            empty_q;
    logic            full_q;
    logic            afull_q;
    logic            in_rdy_q;
    logic [31:0]     in_cnt_q;
    logic [31:0]     out_cnt_q;
    logic            push;
    logic            pop;

    // Ready is a registered flag, so a pop never frees a slot in the same cycle.
    assign push = ht_res_in.valid && in_rdy_q;
    assign pop  = !empty_q && ht_res_out.ready;

    always_comb begin
        used_nxt = used_q;
        if (push && !pop) begin
            used_nxt = used_q + CW'(1);
        end else if (pop && !push) begin
            used_nxt = used_q - CW'(1);
        end
    end

    // Flags are derived from the next count so they line up with used_q.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            in_rdy_q  <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            used_q   <= used_nxt;
            empty_q  <= (used_nxt == CW'(0));
            full_q   <= (used_nxt == CW'(DEPTH));
            afull_q  <= (used_nxt >= CW'(AFULL_LVL));
            in_rdy_q <= (used_nxt != CW'(DEPTH));
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                in_cnt_q <= in_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                out_cnt_q <= out_cnt_q + 32'd1;
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= ht_res_in.result;
        end
    end

    assign ht_res_in.ready   = in_rdy_q;
    assign ht_res_out.valid  = !empty_q;
    assign ht_res_out.result = empty_q ? '0 : mem[rd_ptr_q];

    assign used_words_o  = used_q;
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign in_cnt_o      = in_cnt_q;
    assign out_cnt_o     = out_cnt_q;

endmodule

// File: doc/ht_res_fifo.md
HT_RES_FIFO -- requirements
Module: ht_res_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of result entries held (power of two, at least 2).
REQ-002 SHALL have parameter AFULL_LVL, default DEPTH-2, the occupancy at or above which almost_full_o asserts.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ht_res_in, ht_res_if.slave (result: ht_result_t, valid, ready): the merged result stream from the per-direction result mux.
REQ-006 SHALL have port ht_res_out, ht_res_if.master: the buffered result stream to the consumer.
REQ-007 SHALL have port used_words_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-008 SHALL have ports empty_o, full_o and almost_full_o, each an output of 1 bit: occupancy flags.
REQ-009 SHALL have ports in_cnt_o and out_cnt_o, each an output of 32 bits: total results accepted and total results delivered.

Function
REQ-010 SHALL treat ht_result_t as opaque and store it bit-exact; the output SHALL equal the input, in arrival order.
REQ-011 SHALL accept an input when ht_res_in.valid && ht_res_in.ready (push).
REQ-012 SHALL deliver an output when ht_res_out.valid && ht_res_out.ready (pop).
REQ-013 SHALL drive ht_res_in.ready = !full_o as a registered flag, with no combinational path from ht_res_out.ready.
REQ-014 SHALL be first-word-fall-through: ht_res_out.valid = !empty_o, and ht_res_out.result SHALL be the oldest entry whenever valid is high.
REQ-015 SHALL have a latency of 1 cycle: a push into an empty FIFO SHALL raise ht_res_out.valid on the next cycle, never in the same cycle.
REQ-016 SHALL hold ht_res_out.result and ht_res_out.valid stable while valid=1 and ready=0.
REQ-017 SHALL, on simultaneous push and pop when non-empty and non-full, leave occupancy unchanged and advance both the read and write pointers.
REQ-018 SHALL not accept a push when full, even if a pop occurs in the same cycle; full deasserts on the cycle after the pop.
REQ-019 SHALL ignore ht_res_out.ready when empty: no pointer movement and out_cnt_o unchanged.
REQ-020 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-021 SHALL compute used_words_o as a registered count: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-022 SHALL set empty_o = (used_words_o==0), full_o = (used_words_o==DEPTH) and almost_full_o = (used_words_o>=AFULL_LVL), all consistent with used_words_o in the same cycle.
REQ-023 SHALL increment in_cnt_o by 1 per push and out_cnt_o by 1 per pop, each wrapping modulo 2^32 from 0xFFFFFFFF to 0.
REQ-024 SHALL maintain the invariant in_cnt_o - out_cnt_o (mod 2^32) == used_words_o at all times.

Reset
REQ-025 SHALL, while rst_n_i=0 and independent of clk_i, clear the pointers, used_words_o, in_cnt_o and out_cnt_o to 0.
REQ-026 SHALL, while rst_n_i=0, drive empty_o=1, full_o=0, almost_full_o=0, ht_res_out.valid=0 and ht_res_in.ready=0.
REQ-027 SHALL raise ht_res_in.ready on the first clock edge after rst_n_i deasserts.
REQ-028 SHALL leave storage contents unreset; they SHALL never be observable while empty_o=1.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored results, with no result delivered after reset release that was pushed before it.

Verification
REQ-030 Bench SHALL cover, with DEPTH=4 and consumer ready=0: push results A,B,C,D -> used 1,2,3,4; almost_full at 2; full and in.ready=0 after D; a 5th valid input is not accepted and in_cnt=4.
REQ-031 Bench SHALL cover, from a full FIFO, consumer ready=1 with producer idle: outputs A,B,C,D on 4 consecutive cycles -> out_cnt=4, empty=1, out.valid=0.
REQ-032 Bench SHALL cover, with both valid and ready held high for 20 cycles starting from occupancy 2: one push and one pop per cycle, used stays 2, order preserved, pointers wrap 5 times.
REQ-033 Bench SHALL cover a push into an empty FIFO at cycle t -> out.valid=1 at t+1 with the result equal to the pushed value, and out.valid=0 at t.
REQ-034 Bench SHALL cover rst_n_i asserted asynchronously mid-cycle with occupancy 3 -> all outputs reach reset values immediately, and after release out.valid=0 and in_cnt=out_cnt=0.
REQ-035 Bench SHALL cover counters preloaded by force to 0xFFFFFFFF followed by one push and one pop -> both counters read 0 and used_words is unchanged.
